// File: rtl/trng_ctrl.sv
// Ring-oscillator TRNG controller: restarts the rings, discards warm-up bytes and packs raw bytes into words.
// Runs a repetition-count health test on every sampled byte and latches a sticky fault until en drops.
module trng_ctrl #(
  parameter int WORD_W    = 32,
  parameter int DISCARD   = 64,
  parameter int RCT_LIMIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [7:0]        raw_byte,
  input  logic              raw_valid,
  output logic              str_rst_n,
  output logic [WORD_W-1:0] rnd_data,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic              fault
);

  localparam int NB   = WORD_W / 8;
  localparam int BC_W = $clog2(NB) + 1;
  localparam int DC_W = $clog2(DISCARD + 1);

  typedef enum logic [2:0] {IDLE, RING_RST, WARMUP, COLLECT, FAULT} state_t;

  state_t            state;
  logic [1:0]        rst_sync;
  logic [2:0]        rr_cnt;
  logic [DC_W-1:0]   disc_cnt;
  logic [BC_W-1:0]   byte_cnt;
  logic [WORD_W-1:0] shift;
  logic [7:0]        prev_byte;
  logic [7:0]        run_cnt;

  logic              run_ok;
  logic              take;
  logic              same;
  logic [7:0]        run_nxt;
  logic              rct_hit;
  logic              full_byte;
  logic              xfer;
  logic              stall;
  logic [WORD_W-1:0] shift_nxt;

  // Reset assertion is immediate; release reaches the FSM two clocks later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run_ok    = rst_sync[1];
  assign take      = raw_valid && (state == WARMUP || state == COLLECT);
  assign same      = (run_cnt != 8'd0) && (raw_byte == prev_byte);
  assign run_nxt   = !same ? 8'd1 : ((run_cnt == 8'hFF) ? 8'hFF : run_cnt + 8'd1);
  assign rct_hit   = take && (run_nxt >= 8'(RCT_LIMIT));
  assign full_byte = (byte_cnt == BC_W'(NB - 1));
  assign xfer      = rnd_valid && rnd_ready;
  // A byte that would complete a word while the previous one is still unread is dropped.
  assign stall     = rnd_valid && !rnd_ready && full_byte;
  assign shift_nxt = {shift[WORD_W-9:0], raw_byte};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      str_rst_n <= 1'b0;
      rnd_data  <= '0;
      rnd_valid <= 1'b0;
      fault     <= 1'b0;
      rr_cnt    <= '0;
      disc_cnt  <= '0;
      byte_cnt  <= '0;
      shift     <= '0;
      prev_byte <= '0;
      run_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          str_rst_n <= 1'b0;
          rnd_valid <= 1'b0;
          fault     <= 1'b0;
          if (en && run_ok) begin
            state   <= RING_RST;
            rr_cnt  <= '0;
            run_cnt <= '0;
          end
        end
        RING_RST: begin
          if (!en) begin
            state <= IDLE;
          end else if (rr_cnt == 3'd7) begin
            state     <= WARMUP;
            str_rst_n <= 1'b1;
            disc_cnt  <= '0;
          end else begin
            rr_cnt <= rr_cnt + 3'd1;
          end
        end
        WARMUP, COLLECT: begin
          if (!en) begin
            state     <= IDLE;
            str_rst_n <= 1'b0;
            rnd_valid <= 1'b0;
            byte_cnt  <= '0;
            shift     <= '0;
          end else begin
            if (take) begin
              run_cnt   <= run_nxt;
              prev_byte <= raw_byte;
            end
            if (rct_hit) begin
              state     <= FAULT;
              fault     <= 1'b1;
              str_rst_n <= 1'b0;
              rnd_valid <= 1'b0;
              byte_cnt  <= '0;
            end else if (state == WARMUP) begin
              if (take) begin
                if (disc_cnt == DC_W'(DISCARD - 1)) begin
                  state    <= COLLECT;
                  byte_cnt <= '0;
                  shift    <= '0;
                end else begin
                  disc_cnt <= disc_cnt + DC_W'(1);
                end
              end
            end else begin
              if (xfer) rnd_valid <= 1'b0;
              if (take && !stall) begin
                shift <= shift_nxt;
                if (full_byte) begin
                  rnd_data  <= shift_nxt;
                  rnd_valid <= 1'b1;
                  byte_cnt  <= '0;
                end else begin
                  byte_cnt <= byte_cnt + BC_W'(1);
                end
              end
            end
          end
        end
        FAULT: begin
          str_rst_n <= 1'b0;
          rnd_valid <= 1'b0;
          if (!en) begin
            state <= IDLE;
            fault <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
